// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and the round/saturate helper for the 3x3 conv stage.
package cnn_pkg;

  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 2 * DW + 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (FRAC - 1);
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W + 1)'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN  = -SAT_MAX - (ACC_W + 1)'(1);

  // Round half-up at the FRAC boundary, drop the fraction, clamp to the DW-bit signed range.
  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic signed [DW-1:0] sat_round(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr;
    logic signed [ACC_W:0] clamped;
    rnd = $signed({sum[ACC_W-1], sum}) + RND_HALF;
    shr = rnd >>> FRAC;
    if (shr > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (shr < SAT_MIN) begin
      clamped = SAT_MIN;
    end else begin
      clamped = shr;
    end
    return clamped[DW-1:0];
  endfunction

endpackage

// File: rtl/conv_mac9.sv
// Nine signed multipliers feeding an adder tree, two register stages (products, then sum).
// The valid tag travels with the data and can be flushed when a frame restarts.
module conv_mac9
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    pix [9],
  input  logic signed [DW-1:0]    wgt [9],
  output logic                    sum_valid,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [2*DW-1:0] prod_q [9];
  logic signed [2*DW-1:0] prod_d [9];
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic v1_q, v1_d;
  logic v2_q, v2_d;

  // Multiply each window pixel by its weight and add the previous stage's products together.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = pix[i] * wgt[i];
      sum_d = sum_d + {{(ACC_W - 2 * DW){prod_q[i][2*DW-1]}}, prod_q[i]};
    end
    v1_d = in_valid && !flush;
    v2_d = v1_q && !flush;
  end

  // Product and sum pipeline registers; a flush kills both valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      sum_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      sum_q <= sum_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
    end
  end

  assign sum_valid = v2_q;
  assign sum       = sum_q;

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 sliding-window convolution over a SIZE x SIZE frame fed one 3-pixel column per cycle.
// Holds the FSM, weight file, window, band/column counters, result tags and output rounding.
module conv3x3_mac
  import cnn_pkg::*;
#(
  parameter int SIZE = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_load,
  input  logic [3:0]    w_idx,
  input  logic [DW-1:0] w_data,
  input  logic          srt_sig,
  input  logic          in_valid,
  input  logic [DW-1:0] col_top,
  input  logic [DW-1:0] col_mid,
  input  logic [DW-1:0] col_bot,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [7:0]    out_row,
  output logic [7:0]    out_col,
  output logic          done,
  output logic          busy
);

  state_e state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0] col_cnt_q, col_cnt_d;
  logic [7:0] band_cnt_q, band_cnt_d;

  logic signed [DW-1:0] w_q [9];
  logic signed [DW-1:0] w_d [9];
  logic signed [DW-1:0] win_q [9];
  logic signed [DW-1:0] win_d [9];

  logic [7:0] t1_row_q, t1_row_d, t1_col_q, t1_col_d;
  logic [7:0] t2_row_q, t2_row_d, t2_col_q, t2_col_d;
  logic       t1_last_q, t1_last_d, t2_last_q, t2_last_d;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [7:0]    out_row_q, out_row_d, out_col_q, out_col_d;
  logic          done_q, done_d;

  logic start, accept, win_valid, last_col;
  logic [7:0] cur_col, cur_band;
  logic mac_valid;
  logic signed [ACC_W-1:0] mac_sum;

  // Column acceptance, window shift, counters, FSM and tag capture for the incoming column.
  always_comb begin
    start     = srt_sig && in_valid;
    accept    = in_valid && (start || state_q == ST_RUN);
    cur_col   = start ? 8'd0 : col_cnt_q;
    cur_band  = start ? 8'd0 : band_cnt_q;
    win_valid = accept && (cur_col >= 8'd2);
    last_col  = accept && (cur_col == 8'(SIZE - 1)) && (cur_band == 8'(SIZE - 3));

    w_d = w_q;
    if (w_load && state_q == ST_IDLE && w_idx < 4'd9) begin
      w_d[w_idx] = w_data;
    end

    win_d      = win_q;
    col_cnt_d  = col_cnt_q;
    band_cnt_d = band_cnt_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3+0] = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[2] = col_top;
      win_d[5] = col_mid;
      win_d[8] = col_bot;
      if (cur_col == 8'(SIZE - 1)) begin
        col_cnt_d  = 8'd0;
        band_cnt_d = cur_band + 8'd1;
      end else begin
        col_cnt_d  = cur_col + 8'd1;
        band_cnt_d = cur_band;
      end
    end

    state_d     = state_q;
    drain_cnt_d = 2'd0;
    if (last_col) begin
      state_d = ST_DRAIN;
    end else if (start) begin
      state_d = ST_RUN;
    end else if (state_q == ST_DRAIN) begin
      drain_cnt_d = drain_cnt_q + 2'd1;
      if (drain_cnt_q == 2'd2) begin
        state_d     = ST_IDLE;
        drain_cnt_d = 2'd0;
      end
    end

    t1_row_d  = win_valid ? cur_band : t1_row_q;
    t1_col_d  = win_valid ? (cur_col - 8'd2) : t1_col_q;
    t1_last_d = win_valid ? last_col : t1_last_q;
    t2_row_d  = t1_row_q;
    t2_col_d  = t1_col_q;
    t2_last_d = t1_last_q;
  end

  conv_mac9 u_mac (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .in_valid  (win_valid),
    .pix       (win_d),
    .wgt       (w_q),
    .sum_valid (mac_valid),
    .sum       (mac_sum)
  );

  // Final stage: round and saturate the sum and attach its tags; a restart drops it.
  always_comb begin
    out_valid_d = mac_valid && !start;
    done_d      = out_valid_d && t2_last_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (out_valid_d) begin
      out_data_d = sat_round(mac_sum);
      out_row_d  = t2_row_q;
      out_col_d  = t2_col_q;
    end
  end

  // All state registers; synchronous reset returns everything to zero and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      col_cnt_q   <= '0;
      band_cnt_q  <= '0;
      for (int i = 0; i < 9; i++) begin
        w_q[i]   <= '0;
        win_q[i] <= '0;
      end
      t1_row_q    <= '0;
      t1_col_q    <= '0;
      t1_last_q   <= 1'b0;
      t2_row_q    <= '0;
      t2_col_q    <= '0;
      t2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      col_cnt_q   <= col_cnt_d;
      band_cnt_q  <= band_cnt_d;
      w_q         <= w_d;
      win_q       <= win_d;
      t1_row_q    <= t1_row_d;
      t1_col_q    <= t1_col_d;
      t1_last_q   <= t1_last_d;
      t2_row_q    <= t2_row_d;
      t2_col_q    <= t2_col_d;
      t2_last_q   <= t2_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
